aclk_alarm_sequencer: RTL and testbench
=======================================

# aclk_alarm_sequencer

Alarm ring/snooze sequencer for the alarm clock. It compares the running time against the stored alarm time on each `one_second` strobe and drives the buzzer. It handles snooze by computing a BCD snooze target time, and ends ringing on stop, snooze or auto-timeout. It sits between the time/alarm registers and the buzzer/display logic, in parallel with `aclk_controller`.

## Interface
- `SNOOZE_MIN`, 5: snooze interval in minutes; legal range 1..9.
- `RING_SEC`, 60: number of `one_second` strobes the alarm rings before auto-timeout; legal range 2..63.
- `MAX_SNOOZE`, 3: maximum snoozes per alarm event; legal range 1..3.

- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `one_second`  in  1  one-cycle strobe, once per second.
- `alarm_enable`  in  1  level; 0 disables the alarm.
- `snooze_button`  in  1  level, already debounced.
- `stop_button`  in  1  level, already debounced.
- `cur_time`  in  16  current time, BCD HH:MM as {h_ms, h_ls, m_ms, m_ls}.
- `alarm_time`  in  16  stored alarm time, same format.
- `sound_alarm`  out  1  buzzer drive.
- `snooze_active`  out  1  high while waiting for the snooze target.
- `snooze_count`  out  2  snoozes used in the current alarm event.
- `target_time`  out  16  time currently being matched, BCD.
- `ring_timeout`  out  1  one-cycle pulse on auto-timeout.

## Operation
- State register with 5 states: DISABLED, ARMED, RINGING, SNOOZED, DONE.
- `sound_alarm` = (state == RINGING). `snooze_active` = (state == SNOOZED). Both are decoded from the state register.
- Global priority each cycle: `reset`, then `alarm_enable == 0` (forces DISABLED and clears `snooze_count`), then the per-state rules below.

Per-state rules:
- **DISABLED:** if `alarm_enable` is high, go to ARMED.
- **ARMED:**
  - `target_time` loads `alarm_time` every cycle.
  - If `one_second` is high and `cur_time == alarm_time`, go to RINGING and clear `ring_cnt`.
- **RINGING:**
  - `ring_cnt` increments on each `one_second`.
  - `stop_button` → DONE.
  - Otherwise, `snooze_button` with `snooze_count < MAX_SNOOZE` → SNOOZED. In the same cycle, `target_time` loads `cur_time + SNOOZE_MIN` (BCD) and `snooze_count` increments.
  - `snooze_button` with `snooze_count == MAX_SNOOZE` is ignored.
  - Otherwise, `one_second` with `ring_cnt == RING_SEC-1` → DONE, and `ring_timeout` pulses for 1 cycle.
- **SNOOZED:**
  - `stop_button` → DONE.
  - Otherwise, `one_second` with `cur_time == target_time` → RINGING, clearing `ring_cnt`.
  - `target_time` is held; changes to `alarm_time` do not affect a pending snooze.
- **DONE:**
  - `snooze_count` clears.
  - Stays in DONE while `cur_time == alarm_time`, then goes to ARMED. This blocks re-trigger within the same minute.

Snooze arithmetic:
- Minutes: m = 10·m_ms + m_ls + SNOOZE_MIN.
- If m ≥ 60: subtract 60 and add one hour.
- Hour 23 wraps to 00. Example: 23:58 + 5 → 00:03.
- Result is re-encoded as BCD.

Other rules:
- `ring_cnt` width is ceil(log2(RING_SEC)). It is held at 0 outside RINGING.
- Inputs are valid BCD with hours 00..23; non-BCD input is out of contract.

## Timing
- Reset values: state DISABLED; `sound_alarm` 0; `snooze_active` 0; `snooze_count` 0; `target_time` 16'h0000; `ring_timeout` 0; `ring_cnt` 0.
- All state and register updates occur on the `clk` rising edge.
- Match latency: `one_second` high in cycle N with a time match → `sound_alarm` high from cycle N+1.
- Buttons take effect 1 cycle after they are sampled high. They are level inputs: holding `snooze_button` across the RINGING→SNOOZED transition causes only one snooze, because it is ignored in SNOOZED.
- Ring length: RINGING lasts exactly `RING_SEC` `one_second` strobes when there is no user action.
- `ring_timeout` is high for exactly the 1 cycle after the transition (first cycle in DONE).
- Simultaneous events:
  - `stop_button` and `snooze_button` → stop wins.
  - Stop or snooze on the same cycle as the timeout strobe → the button wins, and there is no `ring_timeout` pulse.
  - `alarm_enable` falling in any state → DISABLED next cycle, and the buzzer is off from that cycle.
- `reset` mid-ring returns everything to its reset value next cycle, with no pulse outputs.

## Test plan
- **Basic ring and timeout:** `alarm_time` = 16'h0730, `cur_time` reaches 16'h0730, strobe at cycle N → `sound_alarm` = 1 from N+1. After 60 further strobes, `ring_timeout` pulses once, `sound_alarm` = 0, and state stays DONE until `cur_time` = 16'h0731.
- **Snooze with wrap:** ringing at 16'h2358, `snooze_button` pressed → `target_time` = 16'h0003, `snooze_active` = 1, `snooze_count` = 1. When `cur_time` = 16'h0003 with a strobe → `sound_alarm` = 1 next cycle.
- **Snooze limit:** 3 snoozes accepted (`snooze_count` = 3). A 4th press while ringing is ignored and `sound_alarm` stays 1. After stop, `snooze_count` = 0 once in DONE.
- **Stop/snooze priority:** `stop_button` and `snooze_button` asserted in the same cycle while ringing → DONE; `snooze_count` unchanged, then cleared.
- **Disable and reset mid-ring:** `alarm_enable` dropped while RINGING → `sound_alarm` = 0 next cycle. Re-enable with `cur_time == alarm_time` → state goes to ARMED and rings again on the next strobe. `reset` asserted while SNOOZED → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/aclk_alarm_sequencer.sv
// aclk_alarm_sequencer
// Watches the running time on each one-second strobe. When the time matches
// the alarm it drives the buzzer. It also handles snooze, which re-targets the
// match to the current time plus SNOOZE_MIN minutes in BCD. Ringing ends on
// stop, on snooze, or when the ring times out.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_DISABLED | alarm switched off, nothing armed
// S_ARMED    | tracking alarm_time_i, waiting for a strobe with a time match
// S_RINGING  | buzzer on, counting strobes toward the auto-timeout
// S_SNOOZED  | buzzer off, waiting for the held snooze target time
// S_DONE     | event finished; blocks re-trigger while still in alarm minute
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   one_second_i          one-cycle strobe per second
//   alarm_enable_i        level, 0 forces S_DISABLED
//   snooze_button_i       debounced level
//   stop_button_i         debounced level
//   cur_time_i            current time, BCD HH:MM
//   alarm_time_i          stored alarm time, BCD HH:MM
//   sound_alarm_o         buzzer drive (S_RINGING)
//   snooze_active_o       waiting on snooze target (S_SNOOZED)
//   snooze_count_o        snoozes used in this alarm event
//   target_time_o         time currently being matched
//   ring_timeout_o        one-cycle pulse on auto-timeout
module aclk_alarm_sequencer #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        one_second_i,
    input  logic        alarm_enable_i,
    input  logic        snooze_button_i,
    input  logic        stop_button_i,
    input  logic [15:0] cur_time_i,
    input  logic [15:0] alarm_time_i,
    output logic        sound_alarm_o,
    output logic        snooze_active_o,
    output logic [1:0]  snooze_count_o,
    output logic [15:0] target_time_o,
    output logic        ring_timeout_o
);

    localparam int CNT_W = (RING_SEC > 1) ? $clog2(RING_SEC) : 1;
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SEC - 1);
    localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);

    typedef enum logic [2:0] {
        S_DISABLED,
        S_ARMED,
        S_RINGING,
        S_SNOOZED,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
    logic [1:0]       snooze_cnt_q, snooze_cnt_d;
    logic [15:0]      target_q, target_d;
    logic             timeout_q, timeout_d;

    // BCD time plus SNOOZE_MIN minutes. The minute total is at most 59+9, so
    // at most one carry into the hours is possible. Hour 24 wraps to 00.
    function automatic logic [15:0] snooze_target(input logic [15:0] t);
        logic [6:0] m;
        logic [4:0] h;
        m = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
        h = 5'(t[15:12]) * 5'd10 + 5'(t[11:8]);
        if (m >= 7'd60) begin
            m = m - 7'd60;
            h = h + 5'd1;
        end
        if (h >= 5'd24) begin
            h = 5'd0;
        end
        return {4'(h / 5'd10), 4'(h % 5'd10), 4'(m / 7'd10), 4'(m % 7'd10)};
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_DISABLED;
            ring_cnt_q   <= '0;
            snooze_cnt_q <= '0;
            target_q     <= 16'h0000;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ring_cnt_q   <= ring_cnt_d;
            snooze_cnt_q <= snooze_cnt_d;
            target_q     <= target_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ring_cnt_d   = '0;          // held at zero except while ringing
        snooze_cnt_d = snooze_cnt_q;
        target_d     = target_q;
        timeout_d    = 1'b0;

        if (!alarm_enable_i) begin
            state_d      = S_DISABLED;
            snooze_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_DISABLED: state_d = S_ARMED;
                S_ARMED: begin
                    target_d = alarm_time_i;
                    if (one_second_i && (cur_time_i == alarm_time_i)) begin
                        state_d = S_RINGING;
                    end
                end
                S_RINGING: begin
                    if (stop_button_i) begin
                        state_d = S_DONE;
                    end else if (snooze_button_i && (snooze_cnt_q < SNZ_MAX)) begin
                        state_d      = S_SNOOZED;
                        target_d     = snooze_target(cur_time_i);
                        snooze_cnt_d = snooze_cnt_q + 2'd1;
                    end else if (one_second_i && (ring_cnt_q == RING_LAST)) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q + CNT_W'(one_second_i);
                    end
                end
                S_SNOOZED: begin
                    if (stop_button_i) begin
                        state_d = S_DONE;
                    end else if (one_second_i && (cur_time_i == target_q)) begin
                        state_d = S_RINGING;
                    end
                end
                S_DONE: begin
                    snooze_cnt_d = '0;
                    if (cur_time_i != alarm_time_i) begin
                        state_d = S_ARMED;
                    end
                end
                default: state_d = S_DISABLED;
            endcase
        end
    end

    assign sound_alarm_o   = (state_q == S_RINGING);
    assign snooze_active_o = (state_q == S_SNOOZED);
    assign snooze_count_o  = snooze_cnt_q;
    assign target_time_o   = target_q;
    assign ring_timeout_o  = timeout_q;

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// Testbench for aclk_alarm_sequencer: directed scenarios, then random
// stimulus. A behavioural model works on minutes-of-day and strobe counts.
module tb_aclk_alarm_sequencer;

    localparam int SNOOZE_MIN = 5;
    localparam int RING_SEC   = 60;
    localparam int MAX_SNOOZE = 3;

    logic        clk_i = 1'b0;
    logic        reset_i, one_second_i, alarm_enable_i;
    logic        snooze_button_i, stop_button_i;
    logic [15:0] cur_time_i, alarm_time_i;
    logic        sound_alarm_o, snooze_active_o, ring_timeout_o;
    logic [1:0]  snooze_count_o;
    logic [15:0] target_time_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    aclk_alarm_sequencer #(
        .SNOOZE_MIN(SNOOZE_MIN),
        .RING_SEC  (RING_SEC),
        .MAX_SNOOZE(MAX_SNOOZE)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .one_second_i   (one_second_i),
        .alarm_enable_i (alarm_enable_i),
        .snooze_button_i(snooze_button_i),
        .stop_button_i  (stop_button_i),
        .cur_time_i     (cur_time_i),
        .alarm_time_i   (alarm_time_i),
        .sound_alarm_o  (sound_alarm_o),
        .snooze_active_o(snooze_active_o),
        .snooze_count_o (snooze_count_o),
        .target_time_o  (target_time_o),
        .ring_timeout_o (ring_timeout_o)
    );

    // ---------------- reference model ----------------
    localparam int M_OFF = 0, M_ARMED = 1, M_RING = 2, M_SNZ = 3, M_DONE = 4;
    int          m_mode    = M_OFF;
    int          m_strobes = 0;      // strobes heard during the current ring
    int          m_snz     = 0;
    logic [15:0] m_target  = 16'h0000;
    logic        m_pulse   = 1'b0;

    function automatic logic [15:0] plus_snooze(input logic [15:0] t);
        int mins;
        mins = (int'(t[15:12]) * 10 + int'(t[11:8])) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
        mins = (mins + SNOOZE_MIN) % 1440;
        return {4'(mins / 600), 4'((mins / 60) % 10), 4'((mins % 60) / 10), 4'(mins % 10)};
    endfunction

    function automatic logic [15:0] rand_time();
        int h, m;
        h = $urandom_range(0, 23);
        m = $urandom_range(0, 59);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic model_step();
        m_pulse = 1'b0;
        if (reset_i) begin
            m_mode = M_OFF; m_strobes = 0; m_snz = 0; m_target = 16'h0000;
        end else if (!alarm_enable_i) begin
            m_mode = M_OFF; m_snz = 0;
        end else begin
            case (m_mode)
                M_OFF: m_mode = M_ARMED;
                M_ARMED: begin
                    m_target = alarm_time_i;
                    if (one_second_i && cur_time_i == alarm_time_i) begin
                        m_mode = M_RING; m_strobes = 0;
                    end
                end
                M_RING: begin
                    if (stop_button_i) m_mode = M_DONE;
                    else if (snooze_button_i && m_snz < MAX_SNOOZE) begin
                        m_mode = M_SNZ; m_snz++; m_target = plus_snooze(cur_time_i);
                    end else if (one_second_i) begin
                        m_strobes++;
                        if (m_strobes == RING_SEC) begin
                            m_mode = M_DONE; m_pulse = 1'b1;
                        end
                    end
                end
                M_SNZ: begin
                    if (stop_button_i) m_mode = M_DONE;
                    else if (one_second_i && cur_time_i == m_target) begin
                        m_mode = M_RING; m_strobes = 0;
                    end
                end
                default: begin
                    m_snz = 0;
                    if (cur_time_i != alarm_time_i) m_mode = M_ARMED;
                end
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply the currently driven inputs for one clock, then compare all outputs.
    task automatic tick();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        chk("sound_alarm", 16'(sound_alarm_o), 16'(m_mode == M_RING));
        chk("snooze_active", 16'(snooze_active_o), 16'(m_mode == M_SNZ));
        chk("snooze_count", 16'(snooze_count_o), 16'(m_snz));
        chk("target_time", target_time_o, m_target);
        chk("ring_timeout", 16'(ring_timeout_o), 16'(m_pulse));
    endtask

    task automatic strobe();
        one_second_i = 1'b1; tick(); one_second_i = 1'b0;
    endtask

    int pulses;

    initial begin
        reset_i = 1'b1; one_second_i = 1'b0; alarm_enable_i = 1'b0;
        snooze_button_i = 1'b0; stop_button_i = 1'b0;
        cur_time_i = 16'h0729; alarm_time_i = 16'h0730;
        @(negedge clk_i);
        tick(); tick();
        chk("reset_target", target_time_o, 16'h0000);
        reset_i = 1'b0; alarm_enable_i = 1'b1;
        tick(); tick();
        strobe();
        chk("no_early_ring", 16'(sound_alarm_o), 16'd0);

        // Basic ring and timeout
        cur_time_i = 16'h0730;
        strobe();
        chk("t1_ring", 16'(sound_alarm_o), 16'd1);
        pulses = 0;
        for (int i = 0; i < RING_SEC; i++) begin
            if (i == RING_SEC - 1) chk("t1_ring_last", 16'(sound_alarm_o), 16'd1);
            strobe();
            pulses += int'(ring_timeout_o);
            tick();
            pulses += int'(ring_timeout_o);
        end
        chk("t1_pulses", 16'(pulses), 16'd1);
        chk("t1_off", 16'(sound_alarm_o), 16'd0);
        strobe(); strobe();
        chk("t1_no_retrigger", 16'(sound_alarm_o), 16'd0);
        cur_time_i = 16'h0731;
        tick(); tick();

        // Snooze with wrap
        alarm_time_i = 16'h2358; cur_time_i = 16'h2358;
        tick();
        strobe();
        chk("t2_ring", 16'(sound_alarm_o), 16'd1);
        snooze_button_i = 1'b1;
        tick();
        chk("t2_target", target_time_o, 16'h0003);
        chk("t2_active", 16'(snooze_active_o), 16'd1);
        chk("t2_count", 16'(snooze_count_o), 16'd1);
        tick();
        chk("t2_held_count", 16'(snooze_count_o), 16'd1);
        snooze_button_i = 1'b0;
        cur_time_i = 16'h0003;
        strobe();
        chk("t2_rering", 16'(sound_alarm_o), 16'd1);

        // Snooze limit
        snooze_button_i = 1'b1; tick(); snooze_button_i = 1'b0;
        chk("t3_target2", target_time_o, 16'h0008);
        cur_time_i = 16'h0008; strobe();
        snooze_button_i = 1'b1; tick(); snooze_button_i = 1'b0;
        chk("t3_count3", 16'(snooze_count_o), 16'd3);
        cur_time_i = 16'h0013; strobe();
        snooze_button_i = 1'b1; tick(); snooze_button_i = 1'b0;
        chk("t3_ignored", 16'(sound_alarm_o), 16'd1);
        chk("t3_count_stays", 16'(snooze_count_o), 16'd3);
        stop_button_i = 1'b1; tick(); stop_button_i = 1'b0;
        tick();
        chk("t3_cleared", 16'(snooze_count_o), 16'd0);

        // Stop and snooze together
        alarm_time_i = 16'h0100; cur_time_i = 16'h0100;
        tick(); strobe();
        snooze_button_i = 1'b1; tick(); snooze_button_i = 1'b0;
        chk("t4_target", target_time_o, 16'h0105);
        cur_time_i = 16'h0105; strobe();
        stop_button_i = 1'b1; snooze_button_i = 1'b1;
        tick();
        stop_button_i = 1'b0; snooze_button_i = 1'b0;
        chk("t4_stop_wins", 16'(snooze_active_o), 16'd0);
        chk("t4_count_kept", 16'(snooze_count_o), 16'd1);
        tick();
        chk("t4_count_clr", 16'(snooze_count_o), 16'd0);

        // Disable and reset mid-ring
        alarm_time_i = 16'h0200; cur_time_i = 16'h0200;
        tick(); strobe();
        alarm_enable_i = 1'b0; tick();
        chk("t5_disable_off", 16'(sound_alarm_o), 16'd0);
        alarm_enable_i = 1'b1; tick();
        strobe();
        chk("t5_rering", 16'(sound_alarm_o), 16'd1);
        snooze_button_i = 1'b1; tick(); snooze_button_i = 1'b0;
        reset_i = 1'b1; tick(); reset_i = 1'b0;
        chk("t5_reset_target", target_time_o, 16'h0000);
        chk("t5_reset_active", 16'(snooze_active_o), 16'd0);

        // Random phase
        alarm_time_i = 16'h1200;
        for (int i = 0; i < 6000; i++) begin
            int sel;
            reset_i         = ($urandom_range(0, 499) == 0);
            alarm_enable_i  = ($urandom_range(0, 99) != 0);
            one_second_i    = ($urandom_range(0, 1) == 0);
            snooze_button_i = ($urandom_range(0, 29) == 0);
            stop_button_i   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 399) == 0) alarm_time_i = rand_time();
            sel = $urandom_range(0, 7);
            if (sel < 3)       cur_time_i = alarm_time_i;
            else if (sel < 5)  cur_time_i = m_target;
            else if (sel == 5) cur_time_i = 16'h2358;
            else               cur_time_i = rand_time();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
